// File: rtl/fru_pla_pkg.sv
// Shared state type and width/offset helpers for the PLA bank and its configuration controller.
package fru_pla_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SAFE = 2'd1,
    DONE      = 2'd2
  } cfg_state_e;

  function automatic int idx_w(input int input_size);
    return (input_size > 2) ? $clog2(input_size) : 1;
  endfunction

  function automatic int mt_w(input int segment_size);
    return 1 << segment_size;
  endfunction

  function automatic int aw_w(input int num_pla);
    return (num_pla > 2) ? $clog2(num_pla) : 1;
  endfunction

  // Config word, LSB first: mux indices, OR-select mask, enable bit.
  function automatic int or_off(input int input_size, input int segment_size);
    return segment_size * idx_w(input_size);
  endfunction

  function automatic int en_off(input int input_size, input int segment_size);
    return or_off(input_size, segment_size) + mt_w(segment_size);
  endfunction

  function automatic int cfg_w(input int input_size, input int segment_size);
    return en_off(input_size, segment_size) + 1;
  endfunction

endpackage

// File: rtl/fru_pla_cfg_slot.sv
// One shadow/active configuration register pair with field unpack for a single PLA.
// FRU_PLA_CFG_READBACK_EN adds a raw word tap of either register.
module fru_pla_cfg_slot
  import fru_pla_pkg::*;
#(
  parameter int INPUT_SIZE   = 8,
  parameter int SEGMENT_SIZE = 2,
  localparam int IDX_W = idx_w(INPUT_SIZE),
  localparam int MT    = mt_w(SEGMENT_SIZE),
  localparam int CFG_W = cfg_w(INPUT_SIZE, SEGMENT_SIZE)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_en,
  input  logic [CFG_W-1:0]                       wr_data,
  input  logic                                   load,
  output logic [SEGMENT_SIZE-1:0][IDX_W-1:0]     mux,
  output logic [MT-1:0]                          or_sel,
  output logic                                   en
`ifdef FRU_PLA_CFG_READBACK_EN
  , input  logic                                 rd_shadow
  , output logic [CFG_W-1:0]                     rd_word
`endif
);

  localparam int OR_OFF = or_off(INPUT_SIZE, SEGMENT_SIZE);
  localparam int EN_OFF = en_off(INPUT_SIZE, SEGMENT_SIZE);

  logic [CFG_W-1:0] shadow_q;
  logic [CFG_W-1:0] active_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (wr_en) shadow_q <= wr_data;
      if (load)  active_q <= shadow_q;
    end
  end

  // Mux indices sit at the bottom of the word in the same order as the packed array.
  assign mux    = active_q[OR_OFF-1:0];
  assign or_sel = active_q[OR_OFF +: MT];
  assign en     = active_q[EN_OFF];

`ifdef FRU_PLA_CFG_READBACK_EN
  assign rd_word = rd_shadow ? shadow_q : active_q;
`endif

endmodule

// File: rtl/fru_pla_cfg_ctrl.sv
// Shadow-bank configuration controller: atomic commit of all PLA slots at a safe swap point.
// FRU_PLA_CFG_READBACK_EN adds a registered shadow/active readback port.
module fru_pla_cfg_ctrl
  import fru_pla_pkg::*;
#(
  parameter int INPUT_SIZE   = 8,
  parameter int SEGMENT_SIZE = 2,
  parameter int NUM_PLA      = 4,
  parameter int TIMEOUT      = 1024,
  localparam int IDX_W = idx_w(INPUT_SIZE),
  localparam int MT    = mt_w(SEGMENT_SIZE),
  localparam int AW    = aw_w(NUM_PLA),
  localparam int CFG_W = cfg_w(INPUT_SIZE, SEGMENT_SIZE)
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              CfgValid,
  output logic                                              CfgReady,
  input  logic [AW-1:0]                                     CfgAddr,
  input  logic [CFG_W-1:0]                                  CfgData,
  output logic                                              CfgErr,
  input  logic                                              CommitReq,
  input  logic                                              SafeToSwap,
  output logic                                              CommitDone,
  output logic                                              CommitErr,
  output logic [NUM_PLA-1:0][SEGMENT_SIZE-1:0][IDX_W-1:0]   RegMux,
  output logic [NUM_PLA-1:0][MT-1:0]                        RegMintermORSelect,
  output logic [NUM_PLA-1:0]                                PlaEn
`ifdef FRU_PLA_CFG_READBACK_EN
  , input  logic [AW-1:0]                                   RdAddr
  , input  logic                                            RdShadow
  , output logic [CFG_W-1:0]                                RdData
`endif
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  cfg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cfg_err_q;
  logic             commit_err_q;
  logic             accept;
  logic             fields_ok;
  logic             wr_ok;
  logic             load;
  logic             timeout_hit;

  // Gated with rst_n so the port reads not-ready while reset is held.
  assign CfgReady   = rst_n & (state_q == IDLE);
  assign CommitDone = (state_q == DONE);
  assign CfgErr     = cfg_err_q;
  assign CommitErr  = commit_err_q;
  assign accept     = CfgValid & CfgReady;
  assign wr_ok      = accept & fields_ok;

  always_comb begin
    fields_ok = (int'(CfgAddr) < NUM_PLA);
    for (int s = 0; s < SEGMENT_SIZE; s++) begin
      if (int'(CfgData[s*IDX_W +: IDX_W]) >= INPUT_SIZE) fields_ok = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (CommitReq) state_d = WAIT_SAFE;
      end
      WAIT_SAFE: begin
        // A swap point on the same cycle as the last allowed low sample still commits.
        if (SafeToSwap) begin
          load    = 1'b1;
          state_d = DONE;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cfg_err_q    <= 1'b0;
      commit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_err_q    <= accept & ~fields_ok;
      commit_err_q <= timeout_hit;
      if (state_q != WAIT_SAFE) cnt_q <= '0;
      else if (!SafeToSwap)     cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef FRU_PLA_CFG_READBACK_EN
  logic [NUM_PLA-1:0][CFG_W-1:0] rd_words;
`endif

  for (genvar i = 0; i < NUM_PLA; i++) begin : g_slot
    fru_pla_cfg_slot #(
      .INPUT_SIZE   (INPUT_SIZE),
      .SEGMENT_SIZE (SEGMENT_SIZE)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_ok && (int'(CfgAddr) == i)),
      .wr_data (CfgData),
      .load    (load),
      .mux     (RegMux[i]),
      .or_sel  (RegMintermORSelect[i]),
      .en      (PlaEn[i])
`ifdef FRU_PLA_CFG_READBACK_EN
      , .rd_shadow (RdShadow)
      , .rd_word   (rd_words[i])
`endif
    );
  end

`ifdef FRU_PLA_CFG_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       RdData <= '0;
    else if (int'(RdAddr) < NUM_PLA)  RdData <= rd_words[RdAddr];
    else                              RdData <= '0;
  end
`endif

endmodule
